ovi_issue_scheduler: RTL

Out-of-order-completion issue scheduler between the scalar core and the VPU on the OVI interface. It accepts core vector instructions and allocates a scoreboard ID (sb_id) per instruction. It meters issue against VPU credits, sequences dispatch (next_senior/kill) in program order, and returns VPU completions to the core in program order. Up to DEPTH instructions can be in flight, which removes single-outstanding-instruction operation.

---
 rtl/ovi_issue_scheduler_pkg.sv | 38 +++
 rtl/ovi_sb_table.sv | 42 ++++
 rtl/ovi_issue_scheduler.sv | 92 +++++++++
 3 files changed

// File: rtl/ovi_issue_scheduler_pkg.sv
// ovi_issue_scheduler_pkg: OVI bus types, vector CSR snapshot and scoreboard entry shared by the issue scheduler
`ifndef OVI_SBID_WIDTH
`define OVI_SBID_WIDTH 5
`endif
package ovi_issue_scheduler_pkg;
  typedef logic [`OVI_SBID_WIDTH-1:0] sb_id_t;
  typedef struct packed {
    logic [7:0]  vtype;
    logic [15:0] vl;
    logic [13:0] vstart;
    logic [1:0]  vxrm;
    logic        vxsat;
  } v_csr;
  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] scalar_opnd;
    sb_id_t      sb_id;
    v_csr        vcsr;
    logic        valid;
  } vpu_issue_bus;
  typedef struct packed {
    sb_id_t sb_id;
    logic   next_senior;
    logic   kill;
  } vpu_dispatch_bus;
  typedef struct packed {
    logic        valid;
    sb_id_t      sb_id;
    logic [63:0] dest_reg;
  } vpu_completed_bus;
  typedef struct packed {
    logic        alloc;
    logic        disp;
    logic        killed;
    logic        done;
    logic [63:0] dest_reg;
  } sched_entry_t;
endpackage

// File: rtl/ovi_sb_table.sv
// ovi_sb_table: scoreboard entry array with allocate, dispatch-mark, completion-write and head free ports
module ovi_sb_table import ovi_issue_scheduler_pkg::*; #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          alloc_en,
  input  logic [AW-1:0] alloc_idx,
  input  logic          mark_en,
  input  logic          mark_kill,
  input  logic [AW-1:0] mark_idx,
  output logic          mark_ok,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [63:0]   wr_data,
  output logic          wr_ok,
  input  logic [AW-1:0] head_idx,
  input  logic          free_en,
  output sched_entry_t  head_entry
);
  sched_entry_t e [DEPTH];
  assign mark_ok = e[mark_idx].alloc && !e[mark_idx].disp && !e[mark_idx].killed;
  assign wr_ok = e[wr_idx].alloc && !e[wr_idx].killed && !e[wr_idx].done;
  assign head_entry = e[head_idx];
  // entry update; a fresh allocation or a free replaces the whole entry
  always_ff @(posedge CLK)
    for (int i = 0; i < DEPTH; i++)
      if (RST) e[i] <= '0;
      else if (alloc_en && alloc_idx == AW'(i)) e[i] <= '{alloc: 1'b1, default: '0};
      else if (free_en && head_idx == AW'(i)) e[i] <= '0;
      else begin
        if (mark_en && mark_idx == AW'(i)) begin
          e[i].disp <= !mark_kill;
          e[i].killed <= mark_kill;
        end
        if (wr_en && wr_idx == AW'(i)) begin
          e[i].done <= 1'b1;
          e[i].dest_reg <= wr_data;
        end
      end
endmodule

// File: rtl/ovi_issue_scheduler.sv
// ovi_issue_scheduler: credit-metered OVI issue, in-order dispatch and retire; OVI_SCHED_SERIAL_EN limits to one in flight
module ovi_issue_scheduler import ovi_issue_scheduler_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int CREDITS = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CORE_ISSUE_VALID,
  input  logic [31:0]      CORE_ISSUE_INSTR,
  input  logic [63:0]      CORE_ISSUE_SCALAR,
  input  v_csr             CORE_ISSUE_VCSR,
  output logic             CORE_ISSUE_READY,
  input  logic             CORE_COMMIT,
  input  logic             CORE_KILL,
  output logic             CORE_COMPLETED_VALID,
  output logic [63:0]      CORE_COMPLETED_DATA,
  output logic             CORE_HALT,
  output vpu_issue_bus     VPU_ISSUE,
  input  logic             VPU_ISSUE_CREDIT,
  output vpu_dispatch_bus  VPU_DISPATCH,
  input  vpu_completed_bus VPU_COMPLETED,
  output logic             ERR
);
  localparam int AW = $clog2(DEPTH);
  localparam int W = $bits(sb_id_t);
  localparam int CW = $clog2(CREDITS + 1);
  logic [AW-1:0] head, disp, tail, wr_idx;
  logic [AW:0] count;
  logic [CW-1:0] credits;
  logic full, no_cred, accept, req, eligible, do_disp, in_rng, wr_ok, wr_en, hit;
  logic ret_pulse, ret_free, sat, err_now;
  sched_entry_t hd;
  assign full = count == (AW+1)'(DEPTH);
  assign no_cred = credits == '0;
`ifdef OVI_SCHED_SERIAL_EN
  assign accept = CORE_ISSUE_VALID && !no_cred && count == '0 && !RST;
  assign CORE_HALT = full || no_cred || count != '0;
`else
  assign accept = CORE_ISSUE_VALID && !no_cred && !full && !RST;
  assign CORE_HALT = full || no_cred;
`endif
  assign CORE_ISSUE_READY = accept;
  assign req = CORE_COMMIT || CORE_KILL;
  assign do_disp = req && eligible && !RST;
  assign in_rng = {1'b0, VPU_COMPLETED.sb_id} < (W+1)'(DEPTH);
  assign wr_idx = VPU_COMPLETED.sb_id[AW-1:0];
  assign wr_en = VPU_COMPLETED.valid && in_rng && wr_ok;
  assign hit = wr_en && wr_idx == head;
  assign ret_pulse = hd.alloc && hd.disp && (hd.done || hit);
  assign ret_free = ret_pulse || (hd.alloc && hd.killed);
  assign sat = VPU_ISSUE_CREDIT && !accept && credits == CW'(CREDITS);
  assign err_now = (CORE_COMMIT && CORE_KILL) || (req && !eligible) || (VPU_COMPLETED.valid && !wr_en) || sat;
  ovi_sb_table #(.DEPTH(DEPTH)) u_tbl (
    .CLK(CLK), .RST(RST),
    .alloc_en(accept), .alloc_idx(tail),
    .mark_en(do_disp), .mark_kill(CORE_KILL), .mark_idx(disp), .mark_ok(eligible),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(VPU_COMPLETED.dest_reg), .wr_ok(wr_ok),
    .head_idx(head), .free_en(ret_free), .head_entry(hd)
  );
  // VPU issue pass-through and dispatch strobes
  always_comb begin
    VPU_ISSUE.instr = CORE_ISSUE_INSTR;
    VPU_ISSUE.scalar_opnd = CORE_ISSUE_SCALAR;
    VPU_ISSUE.sb_id = sb_id_t'(tail);
    VPU_ISSUE.vcsr = CORE_ISSUE_VCSR;
    VPU_ISSUE.valid = accept;
    VPU_DISPATCH.sb_id = sb_id_t'(disp);
    VPU_DISPATCH.next_senior = do_disp && !CORE_KILL;
    VPU_DISPATCH.kill = do_disp && CORE_KILL;
  end
  // pointers, occupancy, credits, retire register and sticky error
  always_ff @(posedge CLK)
    if (RST) begin
      head <= '0;
      disp <= '0;
      tail <= '0;
      count <= '0;
      credits <= CW'(CREDITS);
      CORE_COMPLETED_VALID <= 1'b0;
      CORE_COMPLETED_DATA <= '0;
      ERR <= 1'b0;
    end else begin
      tail <= tail + AW'(accept);
      disp <= disp + AW'(do_disp);
      head <= head + AW'(ret_free);
      count <= count + (AW+1)'(accept) - (AW+1)'(ret_free);
      credits <= sat ? credits : credits + CW'(VPU_ISSUE_CREDIT) - CW'(accept);
      CORE_COMPLETED_VALID <= ret_pulse;
      if (ret_pulse) CORE_COMPLETED_DATA <= hit ? VPU_COMPLETED.dest_reg : hd.dest_reg;
      ERR <= ERR || err_now;
    end
endmodule
